// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, next-PC selection and the IF/ID
// pipeline register, with a saturating count of accepted fetches.
module instruction_fetch (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] InstrAddress,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [15:0] FetchCount
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr_reg;
  logic [31:0] ifid_pc_plus4_reg;
  logic        ifid_valid_reg;
  logic [15:0] fetch_count_reg;
  logic        redirect;
  logic        load_bubble;
  logic        load_fetch;

  // Wraps modulo 2^32 naturally through the 32-bit adder.
  assign pc_plus4 = pc_reg + 32'd4;
  assign redirect = Jump | BranchTaken;

  // Jump beats branch, and any redirect beats a stall.
  always_comb begin
    pc_next = pc_plus4;
    if (Jump) begin
      pc_next = {JumpTarget[31:2], 2'b00};
    end else if (BranchTaken) begin
      pc_next = {BranchTarget[31:2], 2'b00};
    end else if (Stall) begin
      pc_next = pc_reg;
    end
  end

  // A redirect squashes the instruction fetched on the wrong path.
  always_comb begin
    load_bubble = Flush | redirect;
    load_fetch  = !load_bubble && !Stall;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_reg <= 32'd0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ifid_instr_reg    <= NOP_WORD;
      ifid_pc_plus4_reg <= 32'd0;
      ifid_valid_reg    <= 1'b0;
    end else if (load_bubble) begin
      ifid_instr_reg    <= NOP_WORD;
      ifid_pc_plus4_reg <= 32'd0;
      ifid_valid_reg    <= 1'b0;
    end else if (load_fetch) begin
      ifid_instr_reg    <= Instruction;
      ifid_pc_plus4_reg <= pc_plus4;
      ifid_valid_reg    <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_count_reg <= 16'd0;
    end else if (load_fetch && (fetch_count_reg != 16'hFFFF)) begin
      fetch_count_reg <= fetch_count_reg + 16'd1;
    end
  end

  // The PC is always word aligned, so the memory address is the PC itself.
  assign InstrAddress     = {pc_reg[31:2], 2'b00};
  assign PC               = pc_reg;
  assign IFID_Instruction = ifid_instr_reg;
  assign IFID_PCPlus4     = ifid_pc_plus4_reg;
  assign IFID_Valid       = ifid_valid_reg;
  assign FetchCount       = fetch_count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; instruction memory word i holds i*3,
// indexed by address bits [8:2].
module tb_instruction_fetch;

  logic        Clk;
  logic        Reset;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] InstrAddress;
  logic [31:0] PC;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [15:0] FetchCount;

  int tests_run;
  int tests_failed;

  instruction_fetch dut (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .Stall(Stall),
    .Flush(Flush), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .InstrAddress(InstrAddress),
    .PC(PC), .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .FetchCount(FetchCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always_comb begin
    Instruction = {25'd0, InstrAddress[8:2]} * 32'd3;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
    BranchTarget = 32'd0; JumpTarget = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge Clk);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
  endtask

  task automatic check_state(input string name, input logic [31:0] pc_e,
                             input logic [31:0] ins_e, input logic [31:0] p4_e,
                             input logic val_e, input logic [15:0] cnt_e);
    tests_run++;
    if (PC !== pc_e || InstrAddress !== pc_e || IFID_Instruction !== ins_e ||
        IFID_PCPlus4 !== p4_e || IFID_Valid !== val_e || FetchCount !== cnt_e) begin
      tests_failed++;
      $display("FAIL %s: got pc=%h addr=%h ins=%h p4=%h v=%b cnt=%h required pc=%h ins=%h p4=%h v=%b cnt=%h",
               name, PC, InstrAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount,
               pc_e, ins_e, p4_e, val_e, cnt_e);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_state("reset_state", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
    step();
    check_state("first_fetch", 32'h4, 32'h0, 32'h4, 1'b1, 16'h1);
    $display("[TB] test_reset done");
  endtask

  task automatic test_sequential();
    do_reset();
    repeat (3) step();
    check_state("seq_3_edges", 32'hC, 32'd6, 32'hC, 1'b1, 16'd3);
    $display("[TB] test_sequential done");
  endtask

  task automatic test_stall();
    do_reset();
    repeat (2) step();
    check_state("stall_pre", 32'h8, 32'd3, 32'h8, 1'b1, 16'd2);
    Stall = 1'b1;
    step();
    check_state("stall_1", 32'h8, 32'd3, 32'h8, 1'b1, 16'd2);
    step();
    check_state("stall_2", 32'h8, 32'd3, 32'h8, 1'b1, 16'd2);
    Stall = 1'b0;
    step();
    check_state("stall_release", 32'hC, 32'd6, 32'hC, 1'b1, 16'd3);
    $display("[TB] test_stall done");
  endtask

  task automatic test_branch();
    do_reset();
    repeat (2) step();
    BranchTaken = 1'b1; BranchTarget = 32'h42;
    step();
    check_state("branch_redirect", 32'h40, 32'h0, 32'h0, 1'b0, 16'd2);
    clear_inputs();
    step();
    check_state("branch_target_fetch", 32'h44, 32'd48, 32'h44, 1'b1, 16'd3);
    $display("[TB] test_branch done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (2) step();
    Jump = 1'b1; JumpTarget = 32'h20;
    BranchTaken = 1'b1; BranchTarget = 32'h60; Stall = 1'b1;
    step();
    check_state("jump_wins", 32'h20, 32'h0, 32'h0, 1'b0, 16'd2);
    clear_inputs();
    step();
    check_state("jump_target_fetch", 32'h24, 32'd24, 32'h24, 1'b1, 16'd3);
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_flush();
    do_reset();
    repeat (2) step();
    Flush = 1'b1;
    step();
    check_state("flush_bubble", 32'hC, 32'h0, 32'h0, 1'b0, 16'd2);
    Stall = 1'b1;
    step();
    check_state("flush_over_stall", 32'hC, 32'h0, 32'h0, 1'b0, 16'd2);
    clear_inputs();
    step();
    check_state("flush_recover", 32'h10, 32'd9, 32'h10, 1'b1, 16'd3);
    $display("[TB] test_flush done");
  endtask

  task automatic test_wrap();
    do_reset();
    Jump = 1'b1; JumpTarget = 32'h1FF;
    step();
    check_state("wrap_redirect_align", 32'h1FC, 32'h0, 32'h0, 1'b0, 16'd0);
    clear_inputs();
    step();
    check_state("wrap_word127", 32'h200, 32'd381, 32'h200, 1'b1, 16'd1);
    step();
    check_state("wrap_word0", 32'h204, 32'd0, 32'h204, 1'b1, 16'd2);
    Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    step();
    check_state("pc_wrap_2_32", 32'h0, 32'd381, 32'h0, 1'b1, 16'd3);
    $display("[TB] test_wrap done");
  endtask

  task automatic test_midrun_reset();
    do_reset();
    repeat (12) step();
    check_state("midrun_pre", 32'h30, 32'd33, 32'h30, 1'b1, 16'd12);
    BranchTaken = 1'b1; BranchTarget = 32'h80; Stall = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    check_state("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    clear_inputs();
    @(negedge Clk);
    Reset = 1'b1;
    step();
    check_state("post_reset_fetch", 32'h4, 32'h0, 32'h4, 1'b1, 16'd1);
    $display("[TB] test_midrun_reset done");
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (65534) @(posedge Clk);
    #1;
    tests_run++;
    if (FetchCount !== 16'hFFFE) begin
      tests_failed++;
      $display("FAIL sat_pre: got %h required %h", FetchCount, 16'hFFFE);
    end
    step();
    tests_run++;
    if (FetchCount !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_reach: got %h required %h", FetchCount, 16'hFFFF);
    end
    repeat (2) step();
    tests_run++;
    if (FetchCount !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_hold: got %h required %h", FetchCount, 16'hFFFF);
    end
    $display("[TB] test_saturation done");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    Reset = 1'b0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_simultaneous();
    test_flush();
    test_wrap();
    test_midrun_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
